// File: rtl/pipe_dbg_pkg.sv
// Shared definitions for the pipeline run-control block.
//   state_t   : run-control state encoding (also exported on the state port)
//   DEF_STEPW : default width of the step-length input
//   DEF_CNTW  : default width of the cycle / stall counters
package pipe_dbg_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_BRK  = 2'd3
   } state_t;

   localparam int DEF_STEPW = 8;
   localparam int DEF_CNTW  = 32;

endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clock : counting clock
//   reset : synchronous clear to zero
//   inc   : count enable for this cycle
//   cnt   : current count; sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer for the 5-stage pipeline: one global enable that
// freezes PC and all pipeline registers together, plus run / halt /
// N-cycle step / single PC breakpoint and saturating debug counters.
//   clock, reset  : pipeline clock, synchronous active-high reset
//   run_req       : free-run request (level)
//   halt_req      : halt request (level, highest priority)
//   step_req      : step request (level), step_len enabled cycles (0 -> 1)
//   bp_en/bp_addr : breakpoint enable and PC
//   pc            : current IF-stage PC
//   wpcir         : hazard unit "not stalled"
//   cpu_en        : pipeline enable
//   halted        : state is HALT or BRK
//   bp_hit        : sticky breakpoint flag, cleared on resume
//   state         : current state encoding
//   cyc_cnt       : enabled cycles (saturating)
//   stall_cnt     : enabled cycles with a load-use stall (saturating)
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | stopped by reset, halt_req or step completion; cpu_en=0
// RUN   | free running until halt_req or breakpoint
// STEP  | running step_rem more enabled cycles, then HALT
// BRK   | stopped on breakpoint, pc holds at bp_addr; cpu_en=0
module pipe_run_ctrl
   import pipe_dbg_pkg::*;
#(
   parameter int STEPW = DEF_STEPW,
   parameter int CNTW  = DEF_CNTW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic [STEPW-1:0] step_len,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   input  logic             wpcir,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [1:0]       state,
   output logic [CNTW-1:0]  cyc_cnt,
   output logic [CNTW-1:0]  stall_cnt
);

   state_t           state_q, state_d;
   logic [STEPW-1:0] step_rem_q, step_rem_d;
   logic             bp_skip_q, bp_skip_d;
   logic             bp_hit_q, bp_hit_d;
   logic             bp_match;
   logic             resume_skip;
   logic [STEPW-1:0] step_load;

   // Match is combinational on pc so the enable drops before the
   // instruction at bp_addr is latched into IF/ID. bp_skip masks the
   // match for the one instruction we are resuming from.
   assign bp_match    = bp_en && (pc == bp_addr) && !bp_skip_q;
   assign cpu_en      = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_match;
   assign halted      = (state_q == ST_HALT) || (state_q == ST_BRK);
   assign bp_hit      = bp_hit_q;
   assign state       = state_q;
   assign resume_skip = (state_q == ST_BRK);
   assign step_load   = (step_len == '0) ? STEPW'(1) : step_len;

   always_comb begin
      state_d    = state_q;
      step_rem_d = step_rem_q;
      bp_hit_d   = bp_hit_q;
      // Skip persists while pc is parked on bp_addr (e.g. load-use stall)
      // and drops as soon as the pipeline moves past it.
      bp_skip_d  = (pc != bp_addr) ? 1'b0 : bp_skip_q;

      if (halt_req) begin
         state_d    = ST_HALT;
         step_rem_d = '0;
         bp_skip_d  = 1'b0;
      end else begin
         case (state_q)
            ST_HALT, ST_BRK: begin
               if (run_req) begin
                  state_d  = ST_RUN;
                  bp_hit_d = 1'b0;
                  if (resume_skip) bp_skip_d = 1'b1;
               end else if (step_req) begin
                  state_d    = ST_STEP;
                  step_rem_d = step_load;
                  bp_hit_d   = 1'b0;
                  if (resume_skip) bp_skip_d = 1'b1;
               end
            end
            ST_RUN, ST_STEP: begin
               if (bp_match) begin
                  state_d    = ST_BRK;
                  bp_hit_d   = 1'b1;
                  step_rem_d = '0;
               end else if (state_q == ST_STEP) begin
                  // Not matching here means cpu_en=1; stalled cycles count too.
                  step_rem_d = step_rem_q - STEPW'(1);
                  if (step_rem_q <= STEPW'(1)) begin
                     state_d    = ST_HALT;
                     step_rem_d = '0;
                     bp_skip_d  = 1'b0;
                  end
               end
            end
            default: begin
               state_d = ST_HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_HALT;
         step_rem_q <= '0;
         bp_skip_q  <= 1'b0;
         bp_hit_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_rem_q <= step_rem_d;
         bp_skip_q  <= bp_skip_d;
         bp_hit_q   <= bp_hit_d;
      end
   end

   sat_counter #(.W(CNTW)) u_cyc_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (cpu_en),
      .cnt   (cyc_cnt)
   );

   sat_counter #(.W(CNTW)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (cpu_en && !wpcir),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
module tb_pipe_run_ctrl;
   import pipe_dbg_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run_req = 1'b0;
   logic        halt_req = 1'b0;
   logic        step_req = 1'b0;
   logic [7:0]  step_len = 8'd0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [31:0] pc = 32'h0;
   logic        wpcir = 1'b1;

   logic        cpu_en, halted, bp_hit;
   logic [1:0]  state;
   logic [31:0] cyc_cnt, stall_cnt;

   logic        cpu_en4, halted4, bp_hit4;
   logic [1:0]  state4;
   logic [3:0]  cyc_cnt4, stall_cnt4;

   always #5 clock = ~clock;

   pipe_run_ctrl #(.STEPW(8), .CNTW(32)) dut (
      .clock(clock), .reset(reset), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .step_len(step_len), .bp_en(bp_en), .bp_addr(bp_addr),
      .pc(pc), .wpcir(wpcir), .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
      .state(state), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
   );

   // Narrow-counter build fed the same stimulus; shows saturation at 15.
   pipe_run_ctrl #(.STEPW(8), .CNTW(4)) dut4 (
      .clock(clock), .reset(reset), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .step_len(step_len), .bp_en(bp_en), .bp_addr(bp_addr),
      .pc(pc), .wpcir(wpcir), .cpu_en(cpu_en4), .halted(halted4), .bp_hit(bp_hit4),
      .state(state4), .cyc_cnt(cyc_cnt4), .stall_cnt(stall_cnt4)
   );

   typedef struct {
      string       name;
      logic        en;
      logic [1:0]  st;
      logic        hl;
      logic        bp;
      logic [31:0] cyc;
      logic [31:0] stl;
      logic [3:0]  cyc4;
      logic [3:0]  stl4;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_cyc = 0;
   int   exp_stall = 0;
   logic exp_bp = 1'b0;
   logic pc_auto = 1'b0;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: actual %0h required %0h (t=%0t)", nm, fld, act, req, $time);
      end
   endtask

   // Monitor: one expected record per checked cycle, compared mid-cycle.
   always @(negedge clock) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.name, "cpu_en",    {31'd0, cpu_en},  {31'd0, e.en});
         chk(e.name, "state",     {30'd0, state},   {30'd0, e.st});
         chk(e.name, "halted",    {31'd0, halted},  {31'd0, e.hl});
         chk(e.name, "bp_hit",    {31'd0, bp_hit},  {31'd0, e.bp});
         chk(e.name, "cyc_cnt",   cyc_cnt,          e.cyc);
         chk(e.name, "stall_cnt", stall_cnt,        e.stl);
         chk(e.name, "ctl4", {27'd0, cpu_en4, state4, halted4, bp_hit4},
             {27'd0, e.en, e.st, e.hl, e.bp});
         chk(e.name, "cyc_cnt4",   {28'd0, cyc_cnt4},   {28'd0, e.cyc4});
         chk(e.name, "stall_cnt4", {28'd0, stall_cnt4}, {28'd0, e.stl4});
      end
   end

   // Push the expectation for the current cycle (inputs already applied).
   task automatic expect_cyc(input string nm, input logic en, input logic [1:0] st);
      exp_t e;
      e.name = nm;
      e.en   = en;
      e.st   = st;
      e.hl   = (st == 2'd0) || (st == 2'd3);
      e.bp   = exp_bp;
      e.cyc  = 32'(exp_cyc);
      e.stl  = 32'(exp_stall);
      e.cyc4 = (exp_cyc > 15) ? 4'd15 : 4'(exp_cyc);
      e.stl4 = (exp_stall > 15) ? 4'd15 : 4'(exp_stall);
      sb_q.push_back(e);
      if (en) begin
         exp_cyc++;
         if (!wpcir) exp_stall++;
      end
   endtask

   // Advance to 1 time unit after the next rising edge; emulate the PC
   // register when pc_auto is set (advances by 4 on enabled cycles).
   task automatic next_cycle();
      logic en_seen;
      #2;
      en_seen = cpu_en;
      @(posedge clock);
      #1;
      if (pc_auto && en_seen) pc = pc + 32'd4;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      next_cycle();
      next_cycle();
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         expect_cyc("idle", 1'b0, ST_HALT);
         if (i < 9) next_cycle();
      end

      // Free run: 20 enabled cycles, halt_req on the 20th
      next_cycle(); run_req = 1'b1; expect_cyc("run_req", 1'b0, ST_HALT);
      for (int i = 0; i < 19; i++) begin
         next_cycle(); run_req = 1'b0; expect_cyc("run", 1'b1, ST_RUN);
      end
      next_cycle(); halt_req = 1'b1; expect_cyc("run_last", 1'b1, ST_RUN);
      next_cycle(); halt_req = 1'b0; expect_cyc("run_halted", 1'b0, ST_HALT);

      // Step of 3
      next_cycle(); step_req = 1'b1; step_len = 8'd3; expect_cyc("step3_req", 1'b0, ST_HALT);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); step_req = 1'b0; expect_cyc("step3", 1'b1, ST_STEP);
      end
      next_cycle(); expect_cyc("step3_done", 1'b0, ST_HALT);
      next_cycle(); expect_cyc("step3_idle", 1'b0, ST_HALT);

      // Step length 0 behaves as 1
      next_cycle(); step_req = 1'b1; step_len = 8'd0; expect_cyc("step0_req", 1'b0, ST_HALT);
      next_cycle(); step_req = 1'b0; expect_cyc("step0", 1'b1, ST_STEP);
      next_cycle(); expect_cyc("step0_done", 1'b0, ST_HALT);

      // Breakpoint at 0x0C, run from pc=0
      next_cycle();
      pc = 32'h0; pc_auto = 1'b1; bp_en = 1'b1; bp_addr = 32'h0000_000C; run_req = 1'b1;
      expect_cyc("bp_req", 1'b0, ST_HALT);
      next_cycle(); run_req = 1'b0; expect_cyc("bp_pc0", 1'b1, ST_RUN);
      next_cycle(); expect_cyc("bp_pc4", 1'b1, ST_RUN);
      next_cycle(); expect_cyc("bp_pc8", 1'b1, ST_RUN);
      next_cycle(); expect_cyc("bp_match", 1'b0, ST_RUN);
      next_cycle(); exp_bp = 1'b1; expect_cyc("bp_brk", 1'b0, ST_BRK);
      next_cycle(); expect_cyc("bp_brk_hold", 1'b0, ST_BRK);
      chk("bp_pc_hold", "pc", pc, 32'h0000_000C);
      next_cycle(); run_req = 1'b1; expect_cyc("bp_resume_req", 1'b0, ST_BRK);
      next_cycle(); run_req = 1'b0; exp_bp = 1'b0; expect_cyc("bp_resume", 1'b1, ST_RUN);
      next_cycle(); expect_cyc("bp_pc10", 1'b1, ST_RUN);
      chk("bp_pc_adv", "pc", pc, 32'h0000_0010);
      next_cycle(); halt_req = 1'b1; expect_cyc("bp_halt", 1'b1, ST_RUN);
      next_cycle(); halt_req = 1'b0; bp_en = 1'b0; pc_auto = 1'b0;
      expect_cyc("bp_halted", 1'b0, ST_HALT);

      // Load-use stall of 2 cycles during RUN
      next_cycle(); run_req = 1'b1; expect_cyc("stl_run_req", 1'b0, ST_HALT);
      next_cycle(); run_req = 1'b0; expect_cyc("stl_run0", 1'b1, ST_RUN);
      next_cycle(); wpcir = 1'b0; expect_cyc("stl_run1", 1'b1, ST_RUN);
      next_cycle(); expect_cyc("stl_run2", 1'b1, ST_RUN);
      next_cycle(); wpcir = 1'b1; halt_req = 1'b1; expect_cyc("stl_run3", 1'b1, ST_RUN);
      next_cycle(); halt_req = 1'b0; expect_cyc("stl_run_halted", 1'b0, ST_HALT);

      // Same stall inside a 4-cycle step: still exactly 4 enabled cycles
      next_cycle(); step_req = 1'b1; step_len = 8'd4; expect_cyc("stl_step_req", 1'b0, ST_HALT);
      next_cycle(); step_req = 1'b0; expect_cyc("stl_step0", 1'b1, ST_STEP);
      next_cycle(); wpcir = 1'b0; expect_cyc("stl_step1", 1'b1, ST_STEP);
      next_cycle(); expect_cyc("stl_step2", 1'b1, ST_STEP);
      next_cycle(); wpcir = 1'b1; expect_cyc("stl_step3", 1'b1, ST_STEP);
      next_cycle(); expect_cyc("stl_step_done", 1'b0, ST_HALT);

      // Reset in the middle of a step aborts it and clears the counters
      next_cycle(); step_req = 1'b1; step_len = 8'd5; expect_cyc("rst_step_req", 1'b0, ST_HALT);
      next_cycle(); step_req = 1'b0; expect_cyc("rst_step0", 1'b1, ST_STEP);
      next_cycle(); reset = 1'b1; expect_cyc("rst_step1", 1'b1, ST_STEP);
      exp_cyc = 0; exp_stall = 0; exp_bp = 1'b0;
      next_cycle(); reset = 1'b0; expect_cyc("rst_after", 1'b0, ST_HALT);
      next_cycle(); expect_cyc("rst_idle", 1'b0, ST_HALT);

      next_cycle();
      next_cycle();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: actual %0d pending required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
